// File: rtl/digit_edit_ctl_if.sv
// Configuration-word handshake between the digit editor and the DDS tuning register.
interface digit_edit_ctl_if;
  logic [31:0] cfg_word;
  logic        cfg_valid;
  logic        cfg_ready;

  modport master (output cfg_word, cfg_valid, input cfg_ready);
  modport slave  (input cfg_word, cfg_valid, output cfg_ready);
endinterface

// File: rtl/digit_edit_ctl.sv
// 8-digit hex editor with cursor, commit handshake to the DDS tuning register.
// Optional cursor blink is compiled in with `define DIGIT_BLINK_EN.
module digit_edit_ctl #(
  parameter logic [31:0] INIT_WORD   = 32'h2022214C,
  parameter int          BLINK_TICKS = 250
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1ms,
  input  logic [4:0]         btn_in,
  output logic [31:0]        disp_data,
  output logic [2:0]         cursor,
  output logic               blink_on,
  output logic [7:0]         led,
  digit_edit_ctl_if.master   cfg,
  output logic               busy
);

  typedef enum logic [0:0] {EDIT = 1'b0, COMMIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [4:0]  btn_q;
  logic [4:0]  press;
  logic        do_commit, do_inc, do_dec, do_next, do_prev, do_edit;
  logic [3:0]  nib;

  // History is cleared on reset so a button held through release counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '0;
    else        btn_q <= btn_in;
  end

  assign press = btn_in & ~btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EDIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EDIT:   if (press[4])      state_nxt = COMMIT;
      COMMIT: if (cfg.cfg_ready) state_nxt = EDIT;
      default:                   state_nxt = EDIT;
    endcase
  end

  // Only the highest-priority press acts; presses during COMMIT are dropped.
  always_comb begin
    do_commit = 1'b0;
    do_inc    = 1'b0;
    do_dec    = 1'b0;
    do_next   = 1'b0;
    do_prev   = 1'b0;
    busy      = 1'b0;
    unique case (state)
      EDIT: begin
        if      (press[4]) do_commit = 1'b1;
        else if (press[0]) do_inc    = 1'b1;
        else if (press[2]) do_dec    = 1'b1;
        else if (press[1]) do_next   = 1'b1;
        else if (press[3]) do_prev   = 1'b1;
      end
      COMMIT: busy = 1'b1;
      default: ;
    endcase
  end

  assign do_edit = do_inc | do_dec | do_next | do_prev;
  assign nib     = disp_data[{cursor, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data <= INIT_WORD;
      cursor    <= 3'd0;
    end else begin
      if (do_inc) disp_data[{cursor, 2'b00} +: 4] <= nib + 4'd1;
      if (do_dec) disp_data[{cursor, 2'b00} +: 4] <= nib - 4'd1;
      if (do_next) cursor <= cursor + 3'd1;
      if (do_prev) cursor <= cursor - 3'd1;
    end
  end

  assign led = 8'b0000_0001 << cursor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cfg_word  <= '0;
      cfg.cfg_valid <= 1'b0;
    end else if (do_commit) begin
      cfg.cfg_word  <= disp_data;
      cfg.cfg_valid <= 1'b1;
    end else if (busy && cfg.cfg_ready) begin
      cfg.cfg_valid <= 1'b0;
    end
  end

`ifdef DIGIT_BLINK_EN
  localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [CW-1:0] blink_cnt;
  logic          blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (busy || do_commit || do_edit) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (tick_1ms) begin
      if (blink_cnt == CW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_on = blink_q;
`else
  logic unused_tick;
  assign unused_tick = tick_1ms;
  assign blink_on    = 1'b1;
`endif

endmodule
